// File: rtl/scan_pkg.sv
// scan_pkg: shared definitions for the seven-segment scan controller.
//   - Segment constants ({a,b,c,d,e,f,g}, active-high).
//   - FSM state encoding for the blank/drive phases of each digit dwell.
//   - Parameter legality check used at elaboration time by the top.
// No ports (package).
package scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_ERR = 7'b1001111;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Digit count 2..8, dwell of at least 2 cycles, blanking shorter than the dwell.
  function automatic bit params_legal(input int nd, input int sd, input int bc);
    return (nd >= 32'sd2) && (nd <= 32'sd8) && (sd >= 32'sd2) &&
           (bc >= 32'sd0) && (bc < sd);
  endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// bcd_seg_dec: combinational BCD to seven-segment decoder.
// Ports:
//   bcd  in  4  BCD code; 10..15 decode to the "E" glyph
//   seg  out 7  {a,b,c,d,e,f,g}, active-high
module bcd_seg_dec
  import scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Code to segment pattern lookup.
  always_comb begin
    seg = SEG_ERR;
    case (bcd)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// scan_display_ctrl: time-multiplexed scan controller for a common-cathode
// seven-segment display. Digits are committed to a shadow register only at
// the frame boundary so a frame never shows a mix of old and new data.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
// Ports:
//   clk          in   1             system clock, rising edge
//   rst          in   1             asynchronous active-high reset
//   data_in      in   4*NUM_DIGITS  BCD digits, digit 0 in data_in[3:0]
//   load         in   1             one-cycle request to display data_in
//   seg          out  7             {a,b,c,d,e,f,g}, registered
//   dig_sel      out  NUM_DIGITS    one-hot digit enable, zero while blanking
//   load_ack     out  1             pulse when requested data reaches shadow
//   frame_start  out  1             pulse on first drive cycle of digit 0
module scan_display_ctrl
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    load_ack,
  output logic                    frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 32'sd1) ? $clog2(NUM_DIGITS) : 32'sd1;
  localparam logic [CW-1:0]         CNT_LAST  = CW'(SCAN_DIV - 32'sd1);
  localparam logic [CW-1:0]         CNT_DRIVE = CW'(BLANK_CYC);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 32'sd1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE   = NUM_DIGITS'(1);
  // With no blanking interval the dwell starts directly in DRIVE.
  localparam scan_state_e ST_START = (BLANK_CYC == 32'sd0) ? ST_DRIVE : ST_BLANK;

  if (!params_legal(NUM_DIGITS, SCAN_DIV, BLANK_CYC)) begin : g_bad_params
    $error("scan_display_ctrl: illegal NUM_DIGITS/SCAN_DIV/BLANK_CYC");
  end

  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cnt_nxt_s;
  logic [IW-1:0]           idx_r;
  scan_state_e             state_r;
  scan_state_e             state_nxt_s;
  logic                    cnt_wrap_s;
  logic                    frame_end_s;
  logic                    pending_r;
  logic [4*NUM_DIGITS-1:0] capture_r;
  logic [4*NUM_DIGITS-1:0] shadow_r;
  logic [3:0]              digit_s [NUM_DIGITS];
  logic [3:0]              dec_in_s;
  logic [6:0]              dec_seg_s;
  logic [NUM_DIGITS-1:0]   blank_lz_s;
  logic [6:0]              seg_nxt_s;
  logic [NUM_DIGITS-1:0]   dig_nxt_s;
  logic                    fs_nxt_s;

  assign cnt_wrap_s  = (cnt_r == CNT_LAST);
  assign frame_end_s = cnt_wrap_s && (idx_r == IDX_LAST);
  assign cnt_nxt_s   = cnt_wrap_s ? '0 : cnt_r + CW'(1);

  // Split the shadow register into per-digit codes.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_s[i] = shadow_r[4*i +: 4];
    end
  end

  assign dec_in_s = digit_s[idx_r];

  bcd_seg_dec u_dec (
    .bcd (dec_in_s),
    .seg (dec_seg_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Mark zero digits above the most significant nonzero digit; digit 0 always shows.
  always_comb begin
    logic seen_nz;
    seen_nz    = 1'b0;
    blank_lz_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz       = seen_nz | (digit_s[i] != 4'd0);
      blank_lz_s[i] = ~seen_nz;
    end
  end
`else
  // Every digit is decoded, leading zeros included.
  always_comb begin
    blank_lz_s = '0;
  end
`endif

  // FSM next state: enter DRIVE when the dwell count reaches the blanking length.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BLANK: begin
        if (cnt_nxt_s == CNT_DRIVE) state_nxt_s = ST_DRIVE;
        else                        state_nxt_s = ST_BLANK;
      end
      ST_DRIVE: begin
        if (cnt_wrap_s) state_nxt_s = ST_START;
        else            state_nxt_s = ST_DRIVE;
      end
      default: state_nxt_s = ST_START;
    endcase
  end

  // FSM outputs for the current dwell position, registered below.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    dig_nxt_s = '0;
    fs_nxt_s  = 1'b0;
    case (state_r)
      ST_BLANK: begin
        seg_nxt_s = SEG_OFF;
        dig_nxt_s = '0;
      end
      ST_DRIVE: begin
        dig_nxt_s = DIG_ONE << idx_r;
        if (blank_lz_s[idx_r]) seg_nxt_s = SEG_OFF;
        else                   seg_nxt_s = dec_seg_s;
        fs_nxt_s = (idx_r == '0) && (cnt_r == CNT_DRIVE);
      end
      default: begin
        seg_nxt_s = SEG_OFF;
        dig_nxt_s = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_START;
    else     state_r <= state_nxt_s;
  end

  // Dwell counter and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (cnt_wrap_s) idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    end
  end

  // Load handshake: capture on request, commit to shadow only at the frame boundary.
  // A load on the boundary cycle bypasses the capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 1'b0;
      capture_r <= '0;
      shadow_r  <= '0;
      load_ack  <= 1'b0;
    end else begin
      if (load) capture_r <= data_in;
      if (frame_end_s) begin
        pending_r <= 1'b0;
        load_ack  <= load | pending_r;
        if (load)           shadow_r <= data_in;
        else if (pending_r) shadow_r <= capture_r;
      end else begin
        load_ack <= 1'b0;
        if (load) pending_r <= 1'b1;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg         <= SEG_OFF;
      dig_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_nxt_s;
      dig_sel     <= dig_nxt_s;
      frame_start <= fs_nxt_s;
    end
  end

endmodule

// File: doc/scan_display_ctrl.md
# scan_display_ctrl

Time-multiplexed scan controller for the multi-digit common-cathode seven-segment display on the experiment board. Holds NUM_DIGITS BCD digits in a tear-free shadow register and cycles one shared BCD-to-segment decoder across the digits. Drives one-hot digit enables, with a blanking interval before each digit to suppress ghosting. Sits between the counter/arithmetic datapaths and the board display pins.

## Interface
- NUM_DIGITS, 4, number of scanned digits (2..8)
- SCAN_DIV, 1000, clock cycles each digit is selected (dwell); must be ≥ 2
- BLANK_CYC, 1, cycles at the start of each dwell with everything off; must be < SCAN_DIV
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  4*NUM_DIGITS  BCD digits; digit 0 (rightmost) = data_in[3:0]
- load  input  1  one-cycle strobe requesting display of data_in
- seg  output  7  {a,b,c,d,e,f,g}, active-high segments
- dig_sel  output  NUM_DIGITS  one-hot digit enable, active-high; all-zero while blanking
- load_ack  output  1  one-cycle pulse when requested data reaches the shadow register
- frame_start  output  1  one-cycle pulse when the first drive cycle of digit 0 begins

## Operation
- Dwell counter cnt runs 0..SCAN_DIV-1 and wraps. Digit index idx advances 0→NUM_DIGITS-1→0 each time cnt wraps.
- FSM states:
  - BLANK: cnt < BLANK_CYC; seg=0, dig_sel=0.
  - DRIVE: cnt ≥ BLANK_CYC; dig_sel=1<<idx, seg=decode(shadow[idx]).
  - BLANK→DRIVE when cnt reaches BLANK_CYC; DRIVE→BLANK on cnt wrap.
- Decode:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any code 10..15 = 1001111 ("E").
- Load handshake:
  - A load pulse copies data_in into a capture register and sets pending.
  - A later load before commit overwrites capture; the latest value wins and only one ack is issued.
  - Commit happens at the frame boundary (cnt=SCAN_DIV-1 and idx=NUM_DIGITS-1): if pending, shadow←capture, pending cleared, load_ack=1 next cycle.
  - A load on the boundary cycle itself commits data_in directly at that edge.
- The shadow register never changes mid-frame, so no torn displays.
- Reset mid-operation: everything clears immediately and asynchronously. Any pending load is lost and no ack is issued. Shadow returns to 0.

## Timing
- Reset values:
  - cnt=0, idx=0, pending=0, capture=0, shadow=0
  - seg=0, dig_sel=0, load_ack=0, frame_start=0
- seg, dig_sel, load_ack and frame_start are registered. Each reflects the (cnt, idx, shadow) state of the previous cycle, a 1-cycle latency.
- First DRIVE output appears BLANK_CYC+1 cycles after reset release.
- Frame period is NUM_DIGITS*SCAN_DIV cycles. frame_start repeats with that period.
- Worst-case load→ack latency is NUM_DIGITS*SCAN_DIV cycles. Best case is 1 cycle (load on the boundary cycle).
- cnt width is $clog2(SCAN_DIV). idx width is $clog2(NUM_DIGITS), minimum 1.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: starting from digit NUM_DIGITS-1 downward, each zero digit is shown as seg=0 until the first nonzero digit. dig_sel timing is unchanged. Digit 0 is always displayed, so value 0 shows a single "0".
  - Undefined: every digit is decoded, including leading zeros.

## Structure
- Shared package/header scan_pkg:
  - segment constants SEG_OFF=7'b0000000, SEG_ERR=7'b1001111
  - FSM state encoding ST_BLANK/ST_DRIVE
  - the parameter legality checks
- One sub-module, bcd_seg_dec: combinational 4-bit BCD to 7-segment decoder using the table above. It is instantiated once and shared via a mux indexed by idx.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
1. Reset release with no load → digits 0..3 each show seg=1111110, dig_sel 0001,0010,0100,1000 for 6 cycles each, preceded by 2 all-zero cycles. frame_start every 32 cycles.
2. load with data_in=16'h1234 mid-frame → display unchanged until the boundary. load_ack pulses once. Next frame shows 4,3,2,1 on dig 0..3 (0110011, 1111001, 1101101, 0110000).
3. Two loads in one frame (16'h5555 then 16'h0987) → a single load_ack. Next frame shows 7,8,9,0.
4. data_in=16'h00AF → digits 0 and 1 show 1001111. With LEADING_ZERO_BLANK_EN, digits 2 and 3 show seg=0; without it they show 1111110.
5. rst asserted during DRIVE of digit 2 with a load pending → seg=0 and dig_sel=0 immediately. No load_ack. After release, digit 0 shows 0 after 3 cycles.
6. load exactly on the boundary cycle with data_in=16'h4321 → load_ack the next cycle. The very next frame shows 1,2,3,4.
